// File: rtl/samp_pkg.sv
// Shared definitions for the sampling-switch phase generator.
// Holds the FSM state encoding, the default field widths and the
// frame-length helper used when the configuration is latched.
package samp_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int FCNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        GUARD = 2'd2,
        HOLD  = 2'd3
    } samp_state_t;

    // Frame length F = max(period, W + D + 1); the +1 guarantees at least
    // one HOLD cycle so conv_start always has a slot.
    function automatic logic [31:0] frame_len(input logic [31:0] period,
                                              input logic [31:0] w,
                                              input logic [31:0] d);
        logic [31:0] min_len;
        min_len = w + d + 32'd1;
        if (period > min_len) begin
            frame_len = period;
        end else begin
            frame_len = min_len;
        end
    endfunction

endpackage

// File: rtl/samp_timer.sv
// Loadable down-counter shared by the TRACK, GUARD and HOLD phases.
// Ports:
//   clk, rst_b  - clock and synchronous active-low reset
//   load        - load load_val this edge (takes priority over counting)
//   load_val    - phase length minus one
//   done        - count has reached zero (last cycle of the phase)
module samp_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end else begin
            count <= count;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/samp_clkgen.sv
// Phase generator for the analog sampling switch.
// Produces samp/samp_b (switch closed while tracking), a one-cycle
// conv_start strobe after the guard time, busy, and a completed-frame count.
// Ports:
//   clk, rst_b            - clock and synchronous active-low reset
//   en                    - run enable (level); frames repeat while high
//   width, dead, period   - track cycles (0 -> 1), guard cycles, frame length
//   samp, samp_b          - switch control pair, complementary registers
//   conv_start            - strobe in the first HOLD cycle
//   busy                  - high in any state other than IDLE
//   frame_cnt             - completed frames, wraps
module samp_clkgen
    import samp_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int FCNT_W = FCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              en,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  dead,
    input  logic [CNT_W-1:0]  period,
    output logic              samp,
    output logic              samp_b,
    output logic              conv_start,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    // Two extra bits so W + D + 1 never overflows.
    localparam int TW = CNT_W + 2;

    samp_state_t   state;
    logic [TW-1:0] w_r;
    logic [TW-1:0] d_r;
    logic [TW-1:0] f_r;
    logic [TW-1:0] w_in;
    logic [TW-1:0] d_in;
    logic [TW-1:0] f_in;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    assign w_in = (width == '0) ? TW'(1) : TW'(width);
    assign d_in = TW'(dead);
    assign f_in = TW'(frame_len(32'(period), 32'(w_in), 32'(d_in)));

    // Timer reload on every phase transition; loaded value is length-1.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (en) begin
                    tmr_load = 1'b1;
                    tmr_val  = w_in - TW'(1);
                end else begin
                    tmr_load = 1'b0;
                end
            end
            TRACK: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (d_r != '0) begin
                        tmr_val = d_r - TW'(1);
                    end else begin
                        tmr_val = f_r - w_r - TW'(1);
                    end
                end else begin
                    tmr_load = 1'b0;
                end
            end
            GUARD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = f_r - w_r - d_r - TW'(1);
                end else begin
                    tmr_load = 1'b0;
                end
            end
            HOLD: begin
                if (tmr_done && en) begin
                    tmr_load = 1'b1;
                    tmr_val  = w_in - TW'(1);
                end else begin
                    tmr_load = 1'b0;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    samp_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // FSM with registered outputs; outputs are set on the transition edge
    // so they line up with the state they decode.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state      <= IDLE;
            w_r        <= '0;
            d_r        <= '0;
            f_r        <= '0;
            samp       <= 1'b0;
            samp_b     <= 1'b1;
            conv_start <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            conv_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state  <= TRACK;
                        w_r    <= w_in;
                        d_r    <= d_in;
                        f_r    <= f_in;
                        samp   <= 1'b1;
                        samp_b <= 1'b0;
                        busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                TRACK: begin
                    if (tmr_done) begin
                        samp   <= 1'b0;
                        samp_b <= 1'b1;
                        if (d_r != '0) begin
                            state <= GUARD;
                        end else begin
                            state      <= HOLD;
                            conv_start <= 1'b1;
                        end
                    end else begin
                        state <= TRACK;
                    end
                end
                GUARD: begin
                    if (tmr_done) begin
                        state      <= HOLD;
                        conv_start <= 1'b1;
                    end else begin
                        state <= GUARD;
                    end
                end
                HOLD: begin
                    if (tmr_done) begin
                        frame_cnt <= frame_cnt + FCNT_W'(1);
                        if (en) begin
                            state  <= TRACK;
                            w_r    <= w_in;
                            d_r    <= d_in;
                            f_r    <= f_in;
                            samp   <= 1'b1;
                            samp_b <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        state <= HOLD;
                    end
                end
                default: begin
                    state  <= IDLE;
                    samp   <= 1'b0;
                    samp_b <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_samp_clkgen.sv
// Directed self-checking bench for samp_clkgen (FCNT_W=4 so wrap is short).
module tb_samp_clkgen;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       en;
    logic [7:0] width;
    logic [7:0] dead;
    logic [7:0] period;
    logic       samp;
    logic       samp_b;
    logic       conv_start;
    logic       busy;
    logic [3:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [3:0] fexp;

    samp_clkgen #(.CNT_W(8), .FCNT_W(4)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .en         (en),
        .width      (width),
        .dead       (dead),
        .period     (period),
        .samp       (samp),
        .samp_b     (samp_b),
        .conv_start (conv_start),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, check complementary pair.
    task automatic step();
        logic nb;
        @(posedge clk);
        #1;
        nb = ~samp;
        chk("samp_b_compl", {31'd0, samp_b}, {31'd0, nb});
    endtask

    // Pulse en for one edge and check one whole frame of length f.
    task automatic one_frame(input int w, input int d, input int f);
        en = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i <= f; i++) begin
            chk("frm_samp", {31'd0, samp}, (i < w) ? 32'd1 : 32'd0);
            chk("frm_conv", {31'd0, conv_start}, (i == w + d) ? 32'd1 : 32'd0);
            chk("frm_busy", {31'd0, busy}, (i < f) ? 32'd1 : 32'd0);
            if (i < f) step();
        end
        fexp = fexp + 4'd1;
        chk("frm_cnt", {28'd0, frame_cnt}, {28'd0, fexp});
    endtask

    initial begin
        rst_b = 1'b0; en = 1'b0; width = 8'd0; dead = 8'd0; period = 8'd0;
        fexp = 4'd0;
        step();
        step();
        chk("rst_samp",  {31'd0, samp},       32'd0);
        chk("rst_sampb", {31'd0, samp_b},     32'd1);
        chk("rst_conv",  {31'd0, conv_start}, 32'd0);
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_fcnt",  {28'd0, frame_cnt},  32'd0);
        rst_b = 1'b1;
        step();

        // Single frame W=3 D=2 F=10.
        width = 8'd3; dead = 8'd2; period = 8'd10;
        one_frame(3, 2, 10);

        // Back-to-back frames W=2 D=0 F=6.
        width = 8'd2; dead = 8'd0; period = 8'd6;
        en = 1'b1;
        step();
        for (int i = 0; i < 30; i++) begin
            chk("b2b_samp", {31'd0, samp}, ((i % 6) < 2) ? 32'd1 : 32'd0);
            chk("b2b_conv", {31'd0, conv_start}, ((i % 6) == 2) ? 32'd1 : 32'd0);
            chk("b2b_busy", {31'd0, busy}, 32'd1);
            step();
        end
        fexp = fexp + 4'd5;
        chk("b2b_cnt", {28'd0, frame_cnt}, {28'd0, fexp});
        en = 1'b0;
        for (int i = 0; i < 20 && busy; i++) step();
        chk("b2b_idle", {31'd0, busy}, 32'd0);
        fexp = fexp + 4'd1;
        chk("b2b_cnt2", {28'd0, frame_cnt}, {28'd0, fexp});

        // Clamp cases.
        width = 8'd0; dead = 8'd0; period = 8'd0;
        one_frame(1, 0, 2);
        width = 8'd5; dead = 8'd4; period = 8'd3;
        one_frame(5, 4, 10);

        // Period change mid-TRACK: first frame 10, then 4-cycle frames.
        width = 8'd2; dead = 8'd1; period = 8'd10;
        en = 1'b1;
        step();
        for (int i = 0; i <= 18; i++) begin
            chk("chg_samp", {31'd0, samp},
                (i == 0 || i == 1 || i == 10 || i == 11 || i == 14 || i == 15) ? 32'd1 : 32'd0);
            chk("chg_conv", {31'd0, conv_start},
                (i == 3 || i == 13 || i == 17) ? 32'd1 : 32'd0);
            chk("chg_busy", {31'd0, busy}, (i < 18) ? 32'd1 : 32'd0);
            if (i == 1) period = 8'd4;
            if (i == 16) en = 1'b0;
            if (i < 18) step();
        end
        fexp = fexp + 4'd3;
        chk("chg_cnt", {28'd0, frame_cnt}, {28'd0, fexp});

        // Reset during GUARD (W=3 -> GUARD at offsets 3..6).
        width = 8'd3; dead = 8'd4; period = 8'd10;
        en = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_b = 1'b0;
        step();
        chk("gr_samp",  {31'd0, samp},       32'd0);
        chk("gr_sampb", {31'd0, samp_b},     32'd1);
        chk("gr_busy",  {31'd0, busy},       32'd0);
        chk("gr_conv",  {31'd0, conv_start}, 32'd0);
        chk("gr_fcnt",  {28'd0, frame_cnt},  32'd0);
        rst_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("gr_noconv", {31'd0, conv_start}, 32'd0);
            chk("gr_nobusy", {31'd0, busy}, 32'd0);
        end
        fexp = 4'd0;

        // Wrap: 16 frames of F=2 with 4-bit counter.
        width = 8'd0; dead = 8'd0; period = 8'd0;
        en = 1'b1;
        step();
        for (int i = 0; i < 30; i++) step();
        chk("wrap_15", {28'd0, frame_cnt}, 32'd15);
        en = 1'b0;
        step();
        step();
        chk("wrap_0",    {28'd0, frame_cnt}, 32'd0);
        chk("wrap_idle", {31'd0, busy},      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/samp_clkgen.md
# samp_clkgen

Digital phase generator that sits directly upstream of the analog sampling switch. It produces the switch control pair `samp`/`samp_b` and a one-cycle `conv_start` strobe that launches the downstream conversion after a programmable guard time. Sample width, guard time and frame period are run-time programmable, and frames repeat back-to-back while enabled.

## Interface
- `CNT_W`, default 8: width of the `width`, `dead` and `period` configuration fields.
- `FCNT_W`, default 16: width of the frame counter.

- `clk`  in  1  system clock; all logic runs on its rising edge.
- `rst_b`  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `en`  in  1  run enable; level-sensitive.
- `width`  in  CNT_W  track (switch-closed) cycles; 0 is treated as 1.
- `dead`  in  CNT_W  guard cycles between switch open and `conv_start`; 0 allowed.
- `period`  in  CNT_W  nominal frame length in cycles.
- `samp`  out  1  switch control, drives the switch `clk`; 1 = switch closed.
- `samp_b`  out  1  exact registered complement of `samp`, drives the switch `clk_b`.
- `conv_start`  out  1  one-cycle strobe marking the start of hold/conversion.
- `busy`  out  1  high while a frame is in progress (any state except IDLE).
- `frame_cnt`  out  FCNT_W  number of completed frames; wraps modulo 2^FCNT_W.

## Operation
- FSM states: IDLE, TRACK, GUARD, HOLD.
- IDLE with `en`=1 → TRACK. Latch `width`, `dead` and `period` into shadow registers at that edge.
- TRACK: stay for W = max(`width`,1) cycles, then → GUARD if D = `dead` > 0, otherwise → HOLD.
- GUARD: stay for D cycles, then → HOLD.
- HOLD: `conv_start`=1 only in the first HOLD cycle. Stay until frame length F = max(`period`, W+D+1) cycles have elapsed since TRACK entry. HOLD always lasts at least 1 cycle.
- End of HOLD: `frame_cnt`+1.
  - `en`=1 → TRACK, relatch the configuration.
  - `en`=0 → IDLE.
- Configuration changes mid-frame take effect only at the next latch point.
- `en` dropping mid-frame does not truncate the frame. The frame completes and the block then returns to IDLE.
- Output decode (all outputs registered):
  - `samp` = (state==TRACK).
  - `samp_b` = ~`samp`; both come from the same flop edge, so there is no skew cycle.
  - `busy` = (state!=IDLE).
- Internal frame timer is CNT_W+2 bits wide so that W+D+1 cannot overflow.
- Reset values: state IDLE, `samp`=0, `samp_b`=1, `conv_start`=0, `busy`=0, `frame_cnt`=0, timers 0.
- Reset asserted mid-frame: all outputs return to their reset values at that edge. No `conv_start` is emitted for the aborted frame, and `frame_cnt` is not incremented.

## Timing
- `en` first sampled high at edge k (in IDLE): `samp`=1 and `busy`=1 from edge k.
- `samp` falls at edge k+W.
- `conv_start` is high during cycle k+W+D, i.e. asserted at edge k+W+D and deasserted at the next edge.
- Next TRACK (when `en` is still high) begins at edge k+F, and `frame_cnt` increments at that same edge.
- With `en` held high, back-to-back frames have no idle cycle: `samp` has period F and duty W/F.
- Latency from `en` to `samp` is 1 edge. `samp` and `samp_b` are never equal in any cycle.

## Structure
- Shared package `samp_pkg`:
  - `samp_state_t` enum (IDLE, TRACK, GUARD, HOLD).
  - Default `CNT_W`/`FCNT_W` localparams.
  - A helper function computing F = max(period, W+D+1).
- One sub-module `samp_timer`: a loadable down-counter with a `done` flag, reused for the TRACK/GUARD/HOLD durations.
- The top level is the FSM plus output registers. Expected total is roughly 150–250 lines.

## Test plan
- Reset, then `width`=3, `dead`=2, `period`=10, pulse `en` for 1 cycle → exactly one frame:
  - `samp` high for 3 cycles.
  - `conv_start` at offset 5.
  - `busy` low at offset 10.
  - `frame_cnt`=1.
- `en` held high, `width`=2, `dead`=0, `period`=6, run 5 frames →
  - `samp` pattern 110000 repeating with no gap.
  - `conv_start` at offsets 2, 8, 14, 20, 26.
  - `frame_cnt`=5.
- Clamp cases:
  - `width`=0, `dead`=0, `period`=0 → W=1, F=2.
  - `width`=5, `dead`=4, `period`=3 → F=10.
  - Check `samp_b`==~`samp` every cycle.
- Change `period` from 10 to 4 during TRACK with `en` high → current frame stays 10 cycles, next frame is 4 cycles (W+D+1≤4).
- Assert `rst_b`=0 during GUARD → next cycle `samp`=0, `samp_b`=1, `busy`=0, no `conv_start`, `frame_cnt` unchanged (0).
- Preload `frame_cnt` by running 65535 frames, or use `FCNT_W`=4 and run 16 frames → counter wraps to 0.
